nn_layer_sequencer: RTL and testbench

- Control FSM for the time-multiplexed single-layer neural datapath.
- Loads the input vector, then sweeps node indices across every layer, steering the datapath input between input memory and feedback.
- Captures the final-layer outputs and streams them out.
- Owns all node/layer counters and write enables, so the datapath no longer derives its layer count from a node-zero edge.

---
 rtl/nn_pkg.sv | 15 +
 rtl/nn_wrap_counter.sv | 21 ++
 rtl/nn_layer_sequencer.sv | 116 +++++++++++
 tb/tb_nn_layer_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// nn_pkg: shared state encoding, default geometry and index-width helper for the layer sequencer.
package nn_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} seq_state_t;

  localparam int DEF_LAYER_SIZE  = 3;
  localparam int DEF_LAYER_DEPTH = 4;
  localparam int DEF_BIT_SIZE    = 1;

  // Keeps index ports at least one bit wide when a dimension is 1.
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nn_wrap_counter.sv
// nn_wrap_counter: index counter that wraps to 0 after MAX (not at the power of two).
module nn_wrap_counter #(
  parameter int MAX = 2,
  parameter int W   = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         wrap
);

  assign wrap = en && count == W'(MAX);

  always_ff @(posedge clk or negedge rst)
    if (!rst) count <= '0;
    else if (clr) count <= '0;
    else if (en) count <= wrap ? '0 : count + W'(1);

endmodule

// File: rtl/nn_layer_sequencer.sv
// nn_layer_sequencer: load/compute/drain control FSM for the time-multiplexed layer datapath.
// Optional NN_SEQ_PERF_CNT_EN adds a saturating busy-cycle counter (perf_cycles).
module nn_layer_sequencer
  import nn_pkg::*;
#(
  parameter int  LAYER_SIZE  = DEF_LAYER_SIZE,
  parameter int  LAYER_DEPTH = DEF_LAYER_DEPTH,
  parameter int  BIT_SIZE    = DEF_BIT_SIZE,
  localparam int NW          = idx_w(LAYER_SIZE),
  localparam int LW          = idx_w(LAYER_DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BIT_SIZE-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BIT_SIZE-1:0] out_data,
  input  logic [BIT_SIZE-1:0] y,
  output logic [NW-1:0]       node,
  output logic [LW-1:0]       layer,
  output logic [NW-1:0]       addr_node,
  output logic                input_select,
  output logic                input_write_enable,
  output logic                output_write_enable,
  output logic                busy,
  output logic                done
`ifdef NN_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]         perf_cycles
`endif
);

  seq_state_t state;
  logic       fetched;
  logic       start_acc;
  logic       fetch;
  logic       last_hs;
  logic       addr_wrap;
  logic       node_wrap;
  logic       layer_wrap;

  assign start_acc           = state == IDLE && start;
  assign in_ready            = state == LOAD;
  assign input_write_enable  = in_ready && in_valid;
  // y is the read data for the address presented this cycle; it lands in out_data at the edge.
  assign fetch               = state == DRAIN && !fetched && (!out_valid || out_ready);
  assign last_hs             = state == DRAIN && fetched && out_valid && out_ready;
  assign busy                = state != IDLE;
  assign input_select        = layer == '0;
  assign output_write_enable = state == COMPUTE && layer == LW'(LAYER_DEPTH - 1);

  nn_wrap_counter #(.MAX(LAYER_SIZE - 1), .W(NW)) u_addr (
    .clk  (clk),
    .rst  (rst),
    .en   (input_write_enable || fetch),
    .clr  (start_acc),
    .count(addr_node),
    .wrap (addr_wrap)
  );

  nn_wrap_counter #(.MAX(LAYER_SIZE - 1), .W(NW)) u_node (
    .clk  (clk),
    .rst  (rst),
    .en   (state == COMPUTE),
    .clr  (start_acc),
    .count(node),
    .wrap (node_wrap)
  );

  nn_wrap_counter #(.MAX(LAYER_DEPTH - 1), .W(LW)) u_layer (
    .clk  (clk),
    .rst  (rst),
    .en   (node_wrap),
    .clr  (start_acc),
    .count(layer),
    .wrap (layer_wrap)
  );

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state     <= IDLE;
      fetched   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      done      <= 1'b0;
    end else begin
      done <= last_hs;
      case (state)
        IDLE: if (start) begin
          state   <= LOAD;
          fetched <= 1'b0;
        end
        LOAD: if (addr_wrap) state <= COMPUTE;
        COMPUTE: if (layer_wrap) state <= DRAIN;
        DRAIN: if (fetch) begin
          out_data  <= y;
          out_valid <= 1'b1;
          fetched   <= addr_wrap;
        end else if (out_ready) begin
          out_valid <= 1'b0;
          if (out_valid) state <= IDLE;
        end
      endcase
    end

`ifdef NN_SEQ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) perf_cycles <= '0;
    else if (start_acc) perf_cycles <= '0;
    else if (busy && perf_cycles != '1) perf_cycles <= perf_cycles + 32'd1;
`endif

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// tb_nn_layer_sequencer: scenario table plus randomized runs against a behavioural datapath/ordering model.
module tb_nn_layer_sequencer;

  localparam int LS = 3;
  localparam int LD = 4;
  localparam int BS = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BS-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [BS-1:0] out_data;
  logic [BS-1:0] y;
  logic [1:0]    node;
  logic [1:0]    layer;
  logic [1:0]    addr_node;
  logic          input_select;
  logic          iwe;
  logic          owe;
  logic          busy;
  logic          done;
`ifdef NN_SEQ_PERF_CNT_EN
  logic [31:0]   perf_cycles;
`endif

  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  nn_layer_sequencer #(.LAYER_SIZE(LS), .LAYER_DEPTH(LD), .BIT_SIZE(BS)) dut (
    .clk                (clk),
`ifdef NN_SEQ_PERF_CNT_EN
    .perf_cycles        (perf_cycles),
`endif
    .rst                (rst),
    .start              (start),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_data            (in_data),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_data           (out_data),
    .y                  (y),
    .node               (node),
    .layer              (layer),
    .addr_node          (addr_node),
    .input_select       (input_select),
    .input_write_enable (iwe),
    .output_write_enable(owe),
    .busy               (busy),
    .done               (done)
  );

  // Stand-in datapath: input memory, and an output memory holding in^A5 for each captured node.
  logic [BS-1:0] imem [4];
  logic [BS-1:0] omem [4];
  always @(posedge clk) begin
    if (iwe) imem[addr_node] <= in_data;
    if (owe) omem[node] <= imem[node] ^ 8'hA5;
  end
  assign y = omem[addr_node];

  typedef struct {
    int gap;
    int stall_word;
    int stall_len;
    bit spur;
    int exp_drain;
  } vec_t;

  vec_t vecs [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_load(input int gap, input bit rnd, input logic [BS-1:0] din [3], output int lcyc);
    int g;
    lcyc = 0;
    for (int b = 0; b < LS; b++) begin
      g = rnd ? int'($urandom_range(0, 2)) : gap;
      for (int j = 0; j < g; j++) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        #1;
        chk("load_in_ready_gap", int'(in_ready), 1);
        chk("load_iwe_gap", int'(iwe), 0);
        tick();
        lcyc++;
      end
      in_valid = 1'b1;
      in_data  = din[b];
      #1;
      chk("load_in_ready", int'(in_ready), 1);
      chk("load_iwe", int'(iwe), 1);
      chk("load_addr", int'(addr_node), b);
      tick();
      lcyc++;
    end
    in_valid = 1'b0;
  endtask

  task automatic do_run(input vec_t v, input bit rnd);
    logic [BS-1:0] din [3];
    logic [BS-1:0] exp_q [$];
    logic [BS-1:0] pdata;
    int lcyc, dcyc, got, stalls, sl, exp_drain;
    bit rdy, pstall;
    for (int i = 0; i < LS; i++) din[i] = 8'($urandom);
    for (int i = 0; i < LS; i++) exp_q.push_back(din[i] ^ 8'hA5);
    in_valid = 1'b0;
    out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = v.spur;
    chk("busy_after_start", int'(busy), 1);
    do_load(v.gap, rnd, din, lcyc);
    for (int k = 0; k < LS * LD; k++) begin
      chk("cmp_node", int'(node), k % LS);
      chk("cmp_layer", int'(layer), k / LS);
      chk("cmp_input_select", int'(input_select), int'(k / LS == 0));
      chk("cmp_owe", int'(owe), int'(k / LS == LD - 1));
      chk("cmp_in_ready", int'(in_ready), 0);
      chk("cmp_out_valid", int'(out_valid), 0);
      tick();
    end
    start = 1'b0;
    chk("drain_owe", int'(owe), 0);
    chk("drain_node", int'(node), 0);
    chk("drain_first_valid", int'(out_valid), 0);
    dcyc = 0; got = 0; stalls = 0; sl = v.stall_len; pstall = 0; pdata = '0;
    while (got < LS && dcyc < 60) begin
      if (pstall) begin
        chk("stall_valid_hold", int'(out_valid), 1);
        chk("stall_data_hold", int'(out_data), int'(pdata));
      end
      if (out_valid) chk("drain_data", int'(out_data), int'(exp_q[got]));
      if (rnd) rdy = $urandom_range(0, 3) != 0;
      else begin
        rdy = !(out_valid && got == v.stall_word && sl > 0);
        if (!rdy) sl--;
      end
      out_ready = rdy;
      pstall = out_valid && !rdy;
      if (pstall) stalls++;
      pdata = out_data;
      if (out_valid && rdy) got++;
      tick();
      dcyc++;
    end
    if (got < LS) begin
      nfail++;
      $display("FAIL drain_timeout: got %0d words expected %0d", got, LS);
    end
    out_ready = 1'b0;
    exp_drain = rnd ? 4 + stalls : v.exp_drain;
    chk("drain_cycles", dcyc, exp_drain);
    chk("done_pulse", int'(done), 1);
    chk("idle_busy", int'(busy), 0);
    chk("idle_out_valid", int'(out_valid), 0);
    tick();
    chk("done_single", int'(done), 0);
`ifdef NN_SEQ_PERF_CNT_EN
    chk("perf_cycles", int'(perf_cycles), lcyc + LS * LD + dcyc);
    tick();
    tick();
    chk("perf_hold", int'(perf_cycles), lcyc + LS * LD + dcyc);
`endif
  endtask

  initial begin
    logic [BS-1:0] junk [3];
    int lc;
    vec_t rv;
    vecs[0] = '{gap: 0, stall_word: -1, stall_len: 0, spur: 0, exp_drain: 4};
    vecs[1] = '{gap: 2, stall_word: 1, stall_len: 5, spur: 1, exp_drain: 9};
    vecs[2] = '{gap: 1, stall_word: 0, stall_len: 2, spur: 0, exp_drain: 6};
    vecs[3] = '{gap: 0, stall_word: 2, stall_len: 3, spur: 1, exp_drain: 7};
    rv = '{gap: 0, stall_word: -1, stall_len: 0, spur: 0, exp_drain: 0};
    for (int i = 0; i < LS; i++) junk[i] = 8'($urandom);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_input_select", int'(input_select), 1);
    chk("rst_node", int'(node), 0);
    chk("rst_layer", int'(layer), 0);
    chk("rst_addr", int'(addr_node), 0);
    chk("rst_owe", int'(owe), 0);
    for (int i = 0; i < 4; i++) do_run(vecs[i], 1'b0);
    // Abort in the middle of the second layer; no done must follow.
    start = 1'b1;
    tick();
    start = 1'b0;
    do_load(0, 1'b0, junk, lc);
    for (int k = 0; k < 5; k++) tick();
    chk("mid_layer_pre", int'(layer), 1);
    rst = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_node", int'(node), 0);
    chk("abort_layer", int'(layer), 0);
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_input_select", int'(input_select), 1);
    chk("abort_in_ready", int'(in_ready), 0);
    tick();
    chk("abort_done", int'(done), 0);
    rst = 1'b1;
    tick();
    chk("abort_idle_busy", int'(busy), 0);
    chk("abort_idle_done", int'(done), 0);
    for (int r = 0; r < 6; r++) do_run(rv, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
